// File: rtl/frame_pkg.sv
// Frame geometry, pixel type and the scan FSM / FIFO entry types shared between
// the frame-buffer writer engines and the scanout reader.
package frame_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int PIX_W  = 24;
  localparam int ADDR_W = 17;
  localparam int NPIX   = IMG_W * IMG_H;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } scan_state_t;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eol;
  } fifo_entry_t;

endpackage

// File: rtl/frame_scanout_reader_fifo.sv
// Prefetch FIFO between the RAM read port and the pixel stream. Push and pop may
// occur together (including when full); an empty FIFO presents an all-zero head.
module pixel_fifo
  import frame_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  fifo_entry_t            din,
  output fifo_entry_t            dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/frame_scanout_reader.sv
// Reads one IMG_W x IMG_H frame from the shared frame-buffer RAM in row-major
// order and emits it as a valid/ready pixel stream with sof/eol markers.
module frame_scanout_reader #(
  parameter int IMG_W      = frame_pkg::IMG_W,
  parameter int IMG_H      = frame_pkg::IMG_H,
  parameter int ADDR_W     = frame_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_en_r_n,
  output logic [ADDR_W-1:0]          mem_addr_r,
  input  logic [frame_pkg::PIX_W-1:0] mem_data_r,
  output logic                       px_valid,
  input  logic                       px_ready,
  output logic [frame_pkg::PIX_W-1:0] px_data,
  output logic                       px_sof,
  output logic                       px_eol
);

  import frame_pkg::fifo_entry_t;
  import frame_pkg::scan_state_t;
  import frame_pkg::IDLE;
  import frame_pkg::ISSUE;
  import frame_pkg::DRAIN;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  scan_state_t       state_q;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic              sof_tag_q;
  logic              eol_tag_q;
  logic [ADDR_W-1:0] issue_q;
  logic [XW-1:0]     ix_q;
  logic [XW-1:0]     ex_q;
  logic [YW-1:0]     ey_q;

  fifo_entry_t       fifo_din;
  fifo_entry_t       fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              credit;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic              last_pop;

  // Read latency is exactly one cycle, so at most one read is ever in flight.
  assign credit     = !fifo_full && ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);
  assign issue      = (state_q == ISSUE) && credit;
  assign last_issue = issue && (issue_q == ADDR_W'(NPIX - 1));
  assign pop        = !fifo_empty && px_ready;
  assign last_pop   = pop && (state_q == DRAIN) &&
                      (ex_q == XW'(IMG_W - 1)) && (ey_q == YW'(IMG_H - 1));

  assign fifo_din   = '{data: mem_data_r, sof: sof_tag_q, eol: eol_tag_q};

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Issue side walks the linear address and column; emit side tracks (ex, ey).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      sof_tag_q  <= 1'b0;
      eol_tag_q  <= 1'b0;
      issue_q    <= '0;
      ix_q       <= '0;
      ex_q       <= '0;
      ey_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        sof_tag_q <= (issue_q == '0);
        eol_tag_q <= (ix_q == XW'(IMG_W - 1));
        issue_q   <= issue_q + 1'b1;
        ix_q      <= (ix_q == XW'(IMG_W - 1)) ? '0 : ix_q + 1'b1;
      end
      if (pop) begin
        if (ex_q == XW'(IMG_W - 1)) begin
          ex_q <= '0;
          ey_q <= ey_q + 1'b1;
        end else begin
          ex_q <= ex_q + 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            issue_q <= '0;
            ix_q    <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
          end
        end
        ISSUE: begin
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_en_r_n = !issue;
  assign mem_addr_r = issue_q;
  assign px_valid   = !fifo_empty;
  assign px_data    = fifo_dout.data;
  assign px_sof     = fifo_dout.sof;
  assign px_eol     = fifo_dout.eol;

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Self-checking bench for frame_scanout_reader on a reduced 20x6 frame: a RAM
// model, a frame-order reference model and a table of frame scenarios.
module tb_frame_scanout_reader;

  localparam int IMG_W      = 20;
  localparam int IMG_H      = 6;
  localparam int NPIX       = IMG_W * IMG_H;
  localparam int ADDR_W     = 17;
  localparam int PIX_W      = 24;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    int readyPct;
    int restartAt;
    int expDoneCycles;
    int expFirstValid;
    int expDones;
  } frameVec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              px_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              mem_en_r_n;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [PIX_W-1:0]  mem_data_r = '0;
  logic              px_valid;
  logic [PIX_W-1:0]  px_data;
  logic              px_sof;
  logic              px_eol;

  logic [PIX_W-1:0]  ram [NPIX];
  int                checks = 0;
  int                failures = 0;
  int                expIdx = 0;
  int                expAddr = 0;
  int                readsIssued = 0;
  int                doneCount = 0;
  logic              stallPrev = 1'b0;
  logic [PIX_W+1:0]  prevWord = '0;

  frame_scanout_reader #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_en_r_n (mem_en_r_n),
    .mem_addr_r (mem_addr_r),
    .mem_data_r (mem_data_r),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_data    (px_data),
    .px_sof     (px_sof),
    .px_eol     (px_eol)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_en_r_n) mem_data_r <= ram[int'(mem_addr_r) % NPIX];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel k of the frame is ram[k], sof on k==0, eol on every IMG_W-th.
  always @(negedge clk) begin
    if (reset) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("hold_valid", px_valid, 1);
        checkOutput("hold_word", {px_data, px_sof, px_eol}, prevWord);
      end
      stallPrev = px_valid && !px_ready;
      prevWord  = {px_data, px_sof, px_eol};
      if (!mem_en_r_n) begin
        checkOutput("rd_addr", mem_addr_r, expAddr);
        checkOutput("rd_within_frame", expAddr < NPIX, 1);
        expAddr++;
        readsIssued++;
        checkOutput("rd_outstanding_le_depth", (readsIssued - expIdx) <= FIFO_DEPTH, 1);
      end
      if (px_valid && px_ready) begin
        checkOutput("px_within_frame", expIdx < NPIX, 1);
        checkOutput("px_data", px_data, ram[expIdx % NPIX]);
        checkOutput("px_sof", px_sof, expIdx == 0);
        checkOutput("px_eol", px_eol, (expIdx % IMG_W) == IMG_W - 1);
        expIdx++;
      end
      if (done) begin
        doneCount++;
        checkOutput("done_at_last_pixel", expIdx, NPIX);
        checkOutput("busy_low_with_done", busy, 0);
      end
    end
  end

  task automatic resetModel();
    expIdx      = 0;
    expAddr     = 0;
    readsIssued = 0;
    doneCount   = 0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic waitDone(input int readyPct, input int restartAt, output int cyc, output int firstValid);
    bit seen;
    seen       = 1'b0;
    cyc        = 0;
    firstValid = -1;
    while (!seen && cyc < 40 * NPIX) begin
      @(posedge clk);
      #1;
      cyc++;
      if (firstValid < 0 && px_valid) firstValid = cyc;
      if (done) seen = 1'b1;
      px_ready = ($urandom_range(99) < readyPct);
      start    = (expIdx == restartAt);
    end
    start = 1'b0;
    checkOutput("done_seen", seen, 1);
  endtask

  task automatic checkFrameEnd(input int expDones);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count", doneCount, expDones);
    checkOutput("pixel_count", expIdx, NPIX);
    checkOutput("read_count", readsIssued, NPIX);
    checkOutput("busy_idle", busy, 0);
    checkOutput("valid_idle", px_valid, 0);
    checkOutput("no_read_idle", mem_en_r_n, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frameVec_t vecs[4];
    int        cyc;
    int        firstValid;
    bit        reached;

    void'($urandom(32'd1207));
    vecs[0] = '{100, -1, NPIX + 2, 2, 1};
    vecs[1] = '{50,  -1, -1,       2, 1};
    vecs[2] = '{75,  50, -1,       2, 1};
    vecs[3] = '{30,  -1, -1,       2, 1};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_mem_en_r_n", mem_en_r_n, 1);
      checkOutput("rst_px_valid", px_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_addr", mem_addr_r, 0);
      checkOutput("rst_px_data", px_data, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_mem_en_r_n", mem_en_r_n, 1);
      checkOutput("idle_px_valid", px_valid, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
    end

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NPIX; i++) ram[i] = (v == 0) ? PIX_W'(i) : PIX_W'($urandom);
      resetModel();
      px_ready = (vecs[v].readyPct == 100);
      applyStimulus();
      waitDone(vecs[v].readyPct, vecs[v].restartAt, cyc, firstValid);
      checkOutput("first_valid_latency", firstValid, vecs[v].expFirstValid);
      if (vecs[v].expDoneCycles >= 0) checkOutput("done_latency", cyc, vecs[v].expDoneCycles);
      checkFrameEnd(vecs[v].expDones);
    end

    // Stall with the end-of-line pixel at the head until credit runs out.
    resetModel();
    px_ready = 1'b0;
    applyStimulus();
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (px_valid && expIdx == IMG_W - 1) reached = 1'b1;
      px_ready = !reached;
    end
    checkOutput("eol_head_reached", reached, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("eol_stall_valid", px_valid, 1);
      checkOutput("eol_stall_eol", px_eol, 1);
      checkOutput("eol_stall_data", px_data, ram[IMG_W - 1]);
      if (i >= 5) checkOutput("eol_stall_no_read", mem_en_r_n, 1);
    end
    px_ready = 1'b1;
    waitDone(100, -1, cyc, firstValid);
    checkFrameEnd(1);

    // Abort a frame with reset, then run a clean frame.
    resetModel();
    px_ready = 1'b1;
    applyStimulus();
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (expIdx >= 60) reached = 1'b1;
      else px_ready = ($urandom_range(99) < 60);
    end
    checkOutput("mid_frame_reached", reached, 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_px_valid", px_valid, 0);
    checkOutput("abort_mem_en_r_n", mem_en_r_n, 1);
    checkOutput("abort_addr", mem_addr_r, 0);
    checkOutput("abort_px_data", px_data, 0);
    checkOutput("abort_sof_eol", {px_sof, px_eol}, 0);
    checkOutput("abort_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("no_done_from_aborted", doneCount, 0);
    resetModel();
    px_ready = 1'b1;
    applyStimulus();
    waitDone(100, -1, cyc, firstValid);
    checkOutput("restart_first_valid", firstValid, 2);
    checkOutput("restart_done_latency", cyc, NPIX + 2);
    checkFrameEnd(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
